// File: rtl/host_port_arbiter.sv
// host_port_arbiter: round-robin sharing of the single host mem_ctrl port.
// Optional WAIT watchdog is enabled by defining HOST_ARB_TIMEOUT_EN.
module host_port_arbiter #(
  parameter int NUM_CH      = 4,
  parameter int ADDR_W      = 64,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        req_valid,
  input  logic [2*NUM_CH-1:0]      req_op,
  input  logic [ADDR_W*NUM_CH-1:0] req_addr,
  input  logic [DATA_W*NUM_CH-1:0] req_wdata,
  output logic [NUM_CH-1:0]        req_grant,
  output logic [NUM_CH-1:0]        rsp_done,
  output logic [NUM_CH-1:0]        rsp_err,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic [1:0]               hc_op,
  output logic [ADDR_W-1:0]        hc_raw_address,
  output logic [DATA_W-1:0]        hc_wrt_data,
  input  logic                     hc_ready,
  input  logic                     hc_tx_done,
  input  logic                     hc_rd_valid,
  input  logic [DATA_W-1:0]        hc_rd_data
);
  localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_RD  = 2'b01;
  localparam logic [1:0] OP_WR  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_DROP
  } state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     owner_q, owner_d;
  logic [1:0]        op_q, op_d;
  logic [1:0]        hc_op_q, hc_op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [NUM_CH-1:0] grant_q, grant_d;
  logic [NUM_CH-1:0] done_q, done_d;
  logic [NUM_CH-1:0] err_q, err_d;

  logic [PW-1:0]     win_idx;
  logic              win_found;
  logic [1:0]        win_op;
  logic              fin;
  logic              tmo;
  int                j;

`ifdef HOST_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt_q, cnt_d;
`endif

  // First requesting channel strictly after the pointer, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    j         = 0;
    for (int k = 1; k <= NUM_CH; k++) begin
      j = (int'(ptr_q) + k) % NUM_CH;
      if (!win_found && req_valid[j]) begin
        win_found = 1'b1;
        win_idx   = j[PW-1:0];
      end
    end
  end

  assign win_op = req_op[2*win_idx +: 2];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    hc_op_d = OP_NOP;
    grant_d = '0;
    done_d  = '0;
    err_d   = '0;
    fin     = 1'b0;
    tmo     = 1'b0;
`ifdef HOST_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (win_found && hc_ready) begin
          grant_d[win_idx] = 1'b1;
          ptr_d   = win_idx;
          owner_d = win_idx;
          op_d    = win_op;
          addr_d  = req_addr[win_idx*ADDR_W +: ADDR_W];
          wdata_d = req_wdata[win_idx*DATA_W +: DATA_W];
          if (win_op == OP_RD || win_op == OP_WR)
            state_d = S_ISSUE;
          else
            state_d = S_DROP;
        end
      end
      S_ISSUE: begin
        hc_op_d = op_q;
        state_d = S_WAIT;
`ifdef HOST_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      S_WAIT: begin
        // Only the pulse matching the owner's op completes it.
        fin = (op_q == OP_RD) ? hc_rd_valid : hc_tx_done;
        if (fin && op_q == OP_RD)
          rdata_d = hc_rd_data;
`ifdef HOST_ARB_TIMEOUT_EN
        tmo   = !fin && (cnt_q == CW'(TIMEOUT_CYC - 1));
        cnt_d = cnt_q + 1'b1;
`endif
        if (fin || tmo) begin
          done_d[owner_q] = 1'b1;
          err_d[owner_q]  = tmo;
          state_d = S_IDLE;
        end
      end
      S_DROP: begin
        done_d[owner_q] = 1'b1;
        err_d[owner_q]  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= PW'(NUM_CH - 1);
      owner_q <= '0;
      op_q    <= OP_NOP;
      hc_op_q <= OP_NOP;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      grant_q <= '0;
      done_q  <= '0;
      err_q   <= '0;
`ifdef HOST_ARB_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      op_q    <= op_d;
      hc_op_q <= hc_op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef HOST_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign req_grant      = grant_q;
  assign rsp_done       = done_q;
  assign rsp_err        = err_q;
  assign rsp_rdata      = rdata_q;
  assign hc_op          = hc_op_q;
  assign hc_raw_address = addr_q;
  assign hc_wrt_data    = wdata_q;

endmodule

// File: tb/tb_host_port_arbiter.sv
// tb_host_port_arbiter: transaction-level model plus directed scenarios.
// Build with HOST_ARB_TIMEOUT_EN to add the watchdog scenario.
module tb_host_port_arbiter;
  localparam int N   = 4;
  localparam int AW  = 64;
  localparam int DW  = 32;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req_valid;
  logic [2*N-1:0] req_op;
  logic [AW*N-1:0] req_addr;
  logic [DW*N-1:0] req_wdata;
  logic [N-1:0]  req_grant, rsp_done, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    hc_op;
  logic [AW-1:0] hc_raw_address;
  logic [DW-1:0] hc_wrt_data;
  logic          hc_ready;
  logic          hc_tx_done, hc_rd_valid;
  logic [DW-1:0] hc_rd_data;

  host_port_arbiter #(
    .NUM_CH(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_grant(req_grant), .rsp_done(rsp_done),
    .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .hc_op(hc_op), .hc_raw_address(hc_raw_address),
    .hc_wrt_data(hc_wrt_data), .hc_ready(hc_ready),
    .hc_tx_done(hc_tx_done), .hc_rd_valid(hc_rd_valid),
    .hc_rd_data(hc_rd_data)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // mem_ctrl stand-in: answers each op after a programmable delay
  logic          bfm_en = 1'b1;
  int            rd_dly = 5;
  int            wr_dly = 3;
  logic [DW-1:0] rd_val = '0;
  logic          b_tx = 1'b0, b_rv = 1'b0;
  logic          spur_tx = 1'b0;
  int            bcnt = 0;
  logic [1:0]    bop = 2'b00;

  assign hc_tx_done  = b_tx | spur_tx;
  assign hc_rd_valid = b_rv;
  assign hc_rd_data  = rd_val;

  always @(negedge clk) begin
    b_tx = 1'b0;
    b_rv = 1'b0;
    if (!rst_n) bcnt = 0;
    else if (bcnt > 0) begin
      bcnt--;
      if (bcnt == 0) begin
        if (bop == 2'b01) b_rv = 1'b1;
        else b_tx = 1'b1;
      end
    end else if (hc_op != 2'b00 && bfm_en) begin
      bop  = hc_op;
      bcnt = (hc_op == 2'b01) ? rd_dly : wr_dly;
    end
  end

  // Reference model: age of the current transaction in cycles since grant
  logic [N-1:0]  e_grant = '0, e_done = '0, e_err = '0;
  logic [1:0]    e_op = '0;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_wd = '0, e_rd = '0;
  int            m_ptr = N - 1;
  int            m_own = 0;
  int            m_age = 0;
  bit            m_act = 1'b0;
  logic [1:0]    m_op = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_grant = '0; e_done = '0; e_err = '0; e_op = '0;
      e_addr = '0; e_wd = '0; e_rd = '0;
      m_ptr = N - 1; m_act = 1'b0;
    end else begin
      e_grant = '0; e_done = '0; e_err = '0; e_op = '0;
      if (!m_act) begin
        if (hc_ready) begin
          int base;
          base = m_ptr;
          for (int k = 1; k <= N; k++) begin
            int c;
            c = (base + k) % N;
            if (!m_act && req_valid[c]) begin
              m_act = 1'b1; m_own = c; m_ptr = c; m_age = 0;
              m_op   = req_op[2*c +: 2];
              e_addr = req_addr[AW*c +: AW];
              e_wd   = req_wdata[DW*c +: DW];
              e_grant[c] = 1'b1;
            end
          end
        end
      end else begin
        m_age++;
        if (m_op == 2'b00 || m_op == 2'b11) begin
          e_done[m_own] = 1'b1; e_err[m_own] = 1'b1; m_act = 1'b0;
        end else if (m_age == 1) begin
          e_op = m_op;
        end else if ((m_op == 2'b01 && hc_rd_valid) ||
                     (m_op == 2'b10 && hc_tx_done)) begin
          e_done[m_own] = 1'b1;
          if (m_op == 2'b01) e_rd = hc_rd_data;
          m_act = 1'b0;
        end
`ifdef HOST_ARB_TIMEOUT_EN
        else if (m_age - 1 >= TMO) begin
          e_done[m_own] = 1'b1; e_err[m_own] = 1'b1; m_act = 1'b0;
        end
`endif
      end
    end
  end

  function automatic int oh2i(input logic [N-1:0] v);
    int r = -1;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  int cyc = 0;
  int op_cnt = 0;
  int gq[$], gcq[$], dq[$], dcq[$], eq[$];

  always @(negedge clk) begin
    cyc++;
    chk("grant", req_grant, e_grant);
    chk("done", rsp_done, e_done);
    chk("err", rsp_err, e_err);
    chk("hc_op", hc_op, e_op);
    chk("addr", hc_raw_address, e_addr);
    chk("wdata", hc_wrt_data, e_wd);
    chk("rdata", rsp_rdata, e_rd);
    if (req_grant != '0) begin
      gq.push_back(oh2i(req_grant)); gcq.push_back(cyc);
    end
    if (rsp_done != '0) begin
      dq.push_back(oh2i(rsp_done)); dcq.push_back(cyc);
      eq.push_back(int'(rsp_err != '0));
    end
    if (hc_op != 2'b00) op_cnt++;
  end

  bit cont[N];

  task automatic step();
    @(negedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (req_grant[i]) begin
        if (!cont[i]) req_valid[i] = 1'b0;
        else req_wdata[DW*i +: DW] += 32'h100;
      end
  endtask

  task automatic clrq();
    gq.delete(); gcq.delete(); dq.delete(); dcq.delete(); eq.delete();
  endtask

  task automatic wait_g(input int n, input int bound);
    int t = 0;
    while (gq.size() < n && t < bound) begin step(); t++; end
    chk("wait_grant", 64'(gq.size() >= n), 64'd1);
  endtask

  task automatic wait_d(input int n, input int bound);
    int t = 0;
    while (dq.size() < n && t < bound) begin step(); t++; end
    chk("wait_done", 64'(dq.size() >= n), 64'd1);
  endtask

  task automatic set_ch(input int c, input logic [1:0] op,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_op[2*c +: 2]     = op;
    req_addr[AW*c +: AW] = a;
    req_wdata[DW*c +: DW] = d;
    req_valid[c] = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int ops0;
    rst_n = 1'b0; hc_ready = 1'b1;
    req_valid = '0; req_op = '0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < N; i++) cont[i] = 1'b0;
    step(); step();
    chk("rst_grant", req_grant, 0);
    chk("rst_done", rsp_done, 0);
    chk("rst_hc_op", hc_op, 0);
    chk("rst_addr", hc_raw_address, 0);
    rst_n = 1'b1;
    step();

    // single READ, data 5 cycles after hc_op
    clrq(); rd_dly = 5; rd_val = 32'hDEADBEEF;
    set_ch(0, 2'b01, 64'h1000, 32'h0);
    wait_d(1, 40);
    chk("t1_grant_ch", gq[0], 0);
    chk("t1_done_ch", dq[0], 0);
    chk("t1_latency", dcq[0] - gcq[0], 7);
    chk("t1_rdata", rsp_rdata, 32'hDEADBEEF);
    chk("t1_err", eq[0], 0);

    // all channels WRITE continuously; pointer left at ch0
    clrq(); wr_dly = 3;
    for (int i = 0; i < N; i++) begin
      cont[i] = 1'b1;
      set_ch(i, 2'b10, 64'h4000 + 64'(i), 32'hA0 + 32'(i));
    end
    wait_g(8, 200);
    req_valid = '0;
    for (int i = 0; i < N; i++) cont[i] = 1'b0;
    wait_d(8, 100);
    for (int i = 0; i < 8; i++) begin
      chk("t2_grant_order", gq[i], (i + 1) % N);
      chk("t2_done_order", dq[i], (i + 1) % N);
    end

    // illegal op on ch2
    clrq(); ops0 = op_cnt;
    set_ch(2, 2'b11, 64'h2222, 32'h0);
    wait_d(1, 20);
    chk("t3_grant_ch", gq[0], 2);
    chk("t3_latency", dcq[0] - gcq[0], 1);
    chk("t3_err", eq[0], 1);
    step(); step();
    chk("t3_no_hc_op", op_cnt - ops0, 0);

    // spurious tx_done in IDLE and during a READ
    clrq();
    spur_tx = 1'b1; step(); spur_tx = 1'b0;
    step(); step(); step();
    chk("t4_idle_spur", dq.size(), 0);
    rd_dly = 6; rd_val = 32'h12345678;
    set_ch(0, 2'b01, 64'h2000, 32'h0);
    wait_g(1, 20);
    step(); step();
    spur_tx = 1'b1; step(); spur_tx = 1'b0;
    wait_d(1, 40);
    chk("t4_latency", dcq[0] - gcq[0], 8);
    chk("t4_rdata", rsp_rdata, 32'h12345678);

    // reset during ch1 WRITE wait
    clrq(); bfm_en = 1'b0;
    set_ch(1, 2'b10, 64'h5000, 32'h55);
    wait_g(1, 20);
    step(); step(); step(); step();
    rst_n = 1'b0;
    step();
    chk("t5_rst_done", rsp_done, 0);
    chk("t5_rst_rdata", rsp_rdata, 0);
    step();
    rst_n = 1'b1; bfm_en = 1'b1; clrq();
    set_ch(1, 2'b10, 64'h5100, 32'h61);
    set_ch(3, 2'b10, 64'h5300, 32'h63);
    wait_g(2, 60);
    chk("t5_first_grant", gq[0], 1);
    chk("t5_second_grant", gq[1], 3);
    wait_d(2, 40);
    chk("t5_first_done", dq[0], 1);

`ifdef HOST_ARB_TIMEOUT_EN
    clrq(); bfm_en = 1'b0;
    set_ch(0, 2'b10, 64'h6000, 32'h66);
    wait_d(1, 60);
    chk("t6_latency", dcq[0] - gcq[0], TMO + 1);
    chk("t6_err", eq[0], 1);
    spur_tx = 1'b1; step(); spur_tx = 1'b0;
    step(); step(); step();
    chk("t6_late_ignored", dq.size(), 1);
    bfm_en = 1'b1;
`endif

    step(); step();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
